// File: rtl/keypad_pkg.sv
// keypad_pkg: shared codes, FSM encoding and key map for the keypad scanner.
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_WAIT_RELEASE
    } state_e;

    // Rows 0-2 hold digits 1-9; row 3 is *, 0, #.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        if (row == 2'd3)
            return (col == 2'd0) ? KEY_STAR : (col == 2'd1) ? 4'h0 : KEY_HASH;
        return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer, resets to all-ones to match idle pulled-up inputs.
module keypad_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces presses and emits one
// fixed-length code pulse per press on the keypad bus (idle 4'b1111).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 4,
    parameter int DEBOUNCE    = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypad,
    output logic       key_valid
);

    localparam int MAX_A = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    logic [2:0]    cs;
    state_e        state_q, state_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pat_q, pat_d;
    logic [3:0]    keypad_q, keypad_d;
    logic          key_valid_q, key_valid_d;
    logic [CW-1:0] cnt_inc;
    logic          one_low;
    logic [1:0]    col_idx;

    keypad_sync #(.W(3)) u_sync (
        .clk   (clk),
        .rst_n (RST),
        .d     (col_n),
        .q     (cs)
    );

    assign cnt_inc = cnt_q + CW'(1);
    assign one_low = (cs == 3'b110) || (cs == 3'b101) || (cs == 3'b011);
    assign col_idx = !pat_q[0] ? 2'd0 : !pat_q[1] ? 2'd1 : 2'd2;

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        keypad_d    = keypad_q;
        key_valid_d = key_valid_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q == CW'(SCAN_DIV - 1)) begin
                    cnt_d = '0;
                    // Multi-key hits in one row are treated like an empty row.
                    if (one_low) begin
                        pat_d   = cs;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (cs != pat_q) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    cnt_d     = '0;
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    state_d     = ST_EMIT;
                    cnt_d       = '0;
                    keypad_d    = key_code(row_idx_q, col_idx);
                    key_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_EMIT: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d     = ST_WAIT_RELEASE;
                    cnt_d       = '0;
                    keypad_d    = KEY_NONE;
                    key_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_RELEASE: begin
                if (cs != 3'b111) begin
                    cnt_d = '0;
                end else if (cnt_inc == CW'(DEBOUNCE)) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_SCAN;
            row_idx_q   <= '0;
            cnt_q       <= '0;
            pat_q       <= 3'b111;
            keypad_q    <= KEY_NONE;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            keypad_q    <= keypad_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row_n     = ~(4'b0001 << row_idx_q);
    assign keypad    = keypad_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scenarios against a keypad matrix model; pulses are
// collected by a monitor and checked per scenario.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  keypad;
    logic        key_valid;
    logic [11:0] keys = '0;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] codes[$];
    int         lens[$];
    int         bad = 0;
    logic       prev_v = 1'b0;

    always #5 clk = ~clk;

    // Key at (r,c) shorts column c to row r while that row is driven low.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .col_n     (col_n),
        .row_n     (row_n),
        .keypad    (keypad),
        .key_valid (key_valid)
    );

    always @(negedge clk) begin
        if (key_valid) begin
            if (!prev_v) begin
                codes.push_back(keypad);
                lens.push_back(1);
            end else begin
                lens[lens.size()-1] = lens[lens.size()-1] + 1;
                if (keypad != codes[codes.size()-1]) bad++;
            end
        end
        if ((keypad != 4'hF) != key_valid) bad++;
        prev_v <= key_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        codes.delete();
        lens.delete();
        bad = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        @(negedge clk);
        vectors++;
        if (keypad !== 4'hF) begin miscompares++; $display("FAIL reset_keypad got %h want f", keypad); end
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", key_valid); end
        vectors++;
        if (row_n !== 4'b1110) begin miscompares++; $display("FAIL reset_row got %b want 1110", row_n); end
        RST = 1'b1;
        clear_mon();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp = ~(4'b0001 << ((k / 4) % 4));
            vectors++;
            if (row_n !== exp) begin miscompares++; $display("FAIL row_rotate k=%0d got %b want %b", k, row_n, exp); end
        end
    endtask

    task automatic test_hold_five();
        logic [3:0] got;
        clear_mon();
        keys[4] = 1'b1;
        cyc(100);
        vectors++;
        if (codes.size() !== 1) begin miscompares++; $display("FAIL hold5_count got %0d want 1", codes.size()); end
        got = (codes.size() > 0) ? codes[0] : 4'hF;
        vectors++;
        if (got !== 4'h5) begin miscompares++; $display("FAIL hold5_code got %h want 5", got); end
        vectors++;
        if (lens.size() > 0 && lens[0] !== 2) begin miscompares++; $display("FAIL hold5_len got %0d want 2", lens[0]); end
        vectors++;
        if (keypad !== 4'hF || key_valid !== 1'b0) begin miscompares++; $display("FAIL hold5_idle got %h/%b want f/0", keypad, key_valid); end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL hold5_bus got %0d violations want 0", bad); end
        keys[4] = 1'b0;
        cyc(40);
    endtask

    task automatic test_sequence();
        int         idx[3] = '{9, 11, 10};
        logic [3:0] exp[3] = '{4'hA, 4'hB, 4'h0};
        logic [3:0] got;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            keys[idx[i]] = 1'b1;
            cyc(60);
            keys[idx[i]] = 1'b0;
            cyc(40);
        end
        vectors++;
        if (codes.size() !== 3) begin miscompares++; $display("FAIL seq_count got %0d want 3", codes.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < codes.size()) ? codes[i] : 4'hF;
            vectors++;
            if (got !== exp[i]) begin miscompares++; $display("FAIL seq_code[%0d] got %h want %h", i, got, exp[i]); end
            vectors++;
            if (i < lens.size() && lens[i] !== 2) begin miscompares++; $display("FAIL seq_len[%0d] got %0d want 2", i, lens[i]); end
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL seq_bus got %0d violations want 0", bad); end
    endtask

    task automatic test_bounce();
        int         n;
        logic [3:0] r0;
        clear_mon();
        n = 0;
        while (row_n !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 40) begin miscompares++; $display("FAIL bounce_row2 got timeout want row 1011"); end
        keys[6] = 1'b1; cyc(2);
        keys[6] = 1'b0; cyc(1);
        keys[6] = 1'b1; cyc(1);
        keys[6] = 1'b0;
        cyc(60);
        vectors++;
        if (codes.size() !== 0) begin miscompares++; $display("FAIL bounce_pulses got %0d want 0", codes.size()); end
        vectors++;
        if (keypad !== 4'hF) begin miscompares++; $display("FAIL bounce_idle got %h want f", keypad); end
        r0 = row_n;
        n = 0;
        while (row_n === r0 && n < 8) begin @(negedge clk); n++; end
        vectors++;
        if (row_n === r0) begin miscompares++; $display("FAIL bounce_resume got row stuck %b want rotation", row_n); end
    endtask

    task automatic test_multi_and_wait();
        int         n;
        logic [3:0] exp[2] = '{4'h2, 4'h9};
        logic [3:0] got;
        clear_mon();
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        cyc(60);
        vectors++;
        if (codes.size() !== 0) begin miscompares++; $display("FAIL multi_pulses got %0d want 0", codes.size()); end
        keys[0] = 1'b0;
        keys[2] = 1'b0;
        cyc(10);
        keys[1] = 1'b1;
        n = 0;
        while (!(codes.size() == 1 && !key_valid) && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 60) begin miscompares++; $display("FAIL wait2_pulse got timeout want pulse"); end
        keys[8] = 1'b1;
        cyc(10);
        keys[1] = 1'b0;
        cyc(80);
        vectors++;
        if (codes.size() !== 2) begin miscompares++; $display("FAIL two_key_count got %0d want 2", codes.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < codes.size()) ? codes[i] : 4'hF;
            vectors++;
            if (got !== exp[i]) begin miscompares++; $display("FAIL two_key_code[%0d] got %h want %h", i, got, exp[i]); end
            vectors++;
            if (i < lens.size() && lens[i] !== 2) begin miscompares++; $display("FAIL two_key_len[%0d] got %0d want 2", i, lens[i]); end
        end
        keys[8] = 1'b0;
        cyc(40);
    endtask

    task automatic test_reset_mid_emit();
        int         n;
        logic [3:0] got;
        clear_mon();
        keys[7] = 1'b1;
        n = 0;
        while (!key_valid && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 60) begin miscompares++; $display("FAIL rst8_first got timeout want pulse"); end
        RST = 1'b0;
        #1;
        vectors++;
        if (keypad !== 4'hF) begin miscompares++; $display("FAIL rst8_keypad got %h want f", keypad); end
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst8_valid got %b want 0", key_valid); end
        vectors++;
        if (row_n !== 4'b1110) begin miscompares++; $display("FAIL rst8_row got %b want 1110", row_n); end
        cyc(2);
        RST = 1'b1;
        clear_mon();
        cyc(80);
        vectors++;
        if (codes.size() !== 1) begin miscompares++; $display("FAIL rst8_count got %0d want 1", codes.size()); end
        got = (codes.size() > 0) ? codes[0] : 4'hF;
        vectors++;
        if (got !== 4'h8) begin miscompares++; $display("FAIL rst8_code got %h want 8", got); end
        vectors++;
        if (lens.size() > 0 && lens[0] !== 2) begin miscompares++; $display("FAIL rst8_len got %0d want 2", lens[0]); end
        keys[7] = 1'b0;
        cyc(40);
    endtask

    initial begin
        test_reset();
        test_hold_five();
        test_sequence();
        test_bounce();
        test_multi_and_wait();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
